// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall controller:
//   - ctrl_state_e : FSM state encoding (RUN / DIV_WAIT / MEM_WAIT)
//   - CNT_W        : width of the divider countdown
//   - STALL_W      : width of the optional stall cycle counter
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/div_timer.sv
// -----------------------------------------------------------------------------
// div_timer
// Countdown that times the multi-cycle divider.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   load       : load DIV_CYCLES into the countdown (also restarts a busy one)
//   clear      : force the countdown to zero (highest priority, no done pulse)
//   run        : allow the countdown to decrement while nonzero
//   busy       : registered, countdown is nonzero
//   done       : registered one-cycle pulse after a decrement reaches zero
//   busy_next  : combinational, countdown will be nonzero after this edge
// DIV_CYCLES must lie in 2..255 so it fits the 8-bit countdown.
// -----------------------------------------------------------------------------
import pipe_ctrl_pkg::*;

module div_timer #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  logic run,
    output logic busy,
    output logic done,
    output logic busy_next
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             done_nxt_s;
    logic             busy_r;
    logic             done_r;

    // Next countdown value: clear beats load beats decrement.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        done_nxt_s = 1'b0;
        if (clear) begin
            cnt_nxt_s = ZERO;
        end else if (load) begin
            cnt_nxt_s = LOAD_VAL;
        end else if (run && (cnt_r != ZERO)) begin
            cnt_nxt_s  = cnt_r - ONE;
            // Only a natural expiry produces done; clear/restart do not.
            done_nxt_s = (cnt_r == ONE);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    assign busy_next = (cnt_nxt_s != ZERO);

    // Countdown, busy and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= ZERO;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= busy_next;
            done_r <= done_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and stall controller for the 5-stage MIPS pipeline. Drives hold and
// flush controls of the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers and
// times the multi-cycle divider.
// Ports:
//   clk, rst (async active-low)
//   exc, mem_busy, div_start, hilo_use, load_use, branch_taken : hazard requests
//   hold_pc/ifid/idex/exmem, flush_ifid/idex/exmem/memwb       : same-cycle controls
//   pc_exc        : select exception vector
//   div_busy      : divider countdown nonzero
//   div_done      : one-cycle pulse after countdown expiry
//   state         : FSM state (debug)
//   stall_cnt     : cycles with hold_pc=1 (saturating)
// Optional feature: define PIPE_CTRL_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
import pipe_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc,
    input  logic               mem_busy,
    input  logic               div_start,
    input  logic               hilo_use,
    input  logic               load_use,
    input  logic               branch_taken,
    output logic               hold_pc,
    output logic               hold_ifid,
    output logic               hold_idex,
    output logic               hold_exmem,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic               flush_exmem,
    output logic               flush_memwb,
    output logic               pc_exc,
    output logic               div_busy,
    output logic               div_done,
    output logic [1:0]         state,
    output logic [STALL_W-1:0] stall_cnt
);

    ctrl_state_e state_r;
    logic        load_s;
    logic        busy_next_s;
    logic        run_s;

    // A divide is only accepted when neither an exception nor a memory stall
    // owns the cycle.
    assign load_s = div_start && !exc && !mem_busy;
    // The countdown keeps running in every state, including MEM_WAIT.
    assign run_s  = 1'b1;

    div_timer #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_timer (
        .clk       (clk),
        .rst_n     (rst),
        .load      (load_s),
        .clear     (exc),
        .run       (run_s),
        .busy      (div_busy),
        .done      (div_done),
        .busy_next (busy_next_s)
    );

    // Priority hazard resolution: only the highest active row drives outputs.
    always_comb begin
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        hold_idex   = 1'b0;
        hold_exmem  = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        pc_exc      = 1'b0;
        if (exc) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            pc_exc      = 1'b1;
        end else if (mem_busy) begin
            hold_pc     = 1'b1;
            hold_ifid   = 1'b1;
            hold_idex   = 1'b1;
            hold_exmem  = 1'b1;
            flush_memwb = 1'b1;
        end else if (div_busy && hilo_use) begin
            hold_pc     = 1'b1;
            hold_ifid   = 1'b1;
            hold_idex   = 1'b1;
            flush_exmem = 1'b1;
        end else if (load_use) begin
            hold_pc     = 1'b1;
            hold_ifid   = 1'b1;
            flush_idex  = 1'b1;
        end else if (branch_taken) begin
            flush_ifid  = 1'b1;
        end else begin
            hold_pc     = 1'b0;
        end
    end

    // Controller FSM; DIV_WAIT tracks whether the countdown stays nonzero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
        end else if (exc) begin
            state_r <= RUN;
        end else if (mem_busy) begin
            state_r <= MEM_WAIT;
        end else begin
            case (state_r)
                RUN:      state_r <= load_s ? DIV_WAIT : RUN;
                DIV_WAIT: state_r <= busy_next_s ? DIV_WAIT : RUN;
                MEM_WAIT: state_r <= busy_next_s ? DIV_WAIT : RUN;
                default:  state_r <= RUN;
            endcase
        end
    end

    assign state = state_r;

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_r;

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (hold_pc && (stall_cnt_r != {STALL_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = {STALL_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. Each driven cycle pushes its hand-computed
// expected outputs into a queue; a monitor on the falling edge pops one entry
// per cycle and compares it against the DUT.
// Input vector bits: {rst, exc, mem_busy, div_start, hilo_use, load_use, branch_taken}
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc = 1'b0;
    logic        mem_busy = 1'b0;
    logic        div_start = 1'b0;
    logic        hilo_use = 1'b0;
    logic        load_use = 1'b0;
    logic        branch_taken = 1'b0;
    logic        hold_pc, hold_ifid, hold_idex, hold_exmem;
    logic        flush_ifid, flush_idex, flush_exmem, flush_memwb;
    logic        pc_exc, div_busy, div_done;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.DIV_CYCLES(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .exc          (exc),
        .mem_busy     (mem_busy),
        .div_start    (div_start),
        .hilo_use     (hilo_use),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .hold_pc      (hold_pc),
        .hold_ifid    (hold_ifid),
        .hold_idex    (hold_idex),
        .hold_exmem   (hold_exmem),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .flush_exmem  (flush_exmem),
        .flush_memwb  (flush_memwb),
        .pc_exc       (pc_exc),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .state        (state),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        string       nm;
        logic [44:0] v;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [44:0] mon_got;
    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int exp_stall = 0;

    localparam logic [6:0] IDLE = 7'b1000000;
    localparam logic [6:0] DS   = 7'b1001000;

    // Drive one cycle of inputs and queue the expected outputs.
    task automatic cyc(input logic [6:0] iv, input logic [3:0] h, input logic [3:0] f,
                       input logic pce, input logic be, input logic de,
                       input logic [1:0] se, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, exc, mem_busy, div_start, hilo_use, load_use, branch_taken} = iv;
        if (!iv[6]) exp_stall = 0;
        e.nm = nm;
`ifdef PIPE_CTRL_STALL_CNT_EN
        e.v = {h, f, pce, be, de, se, 32'(exp_stall)};
`else
        e.v = {h, f, pce, be, de, se, 32'd0};
`endif
        q.push_back(e);
        if (iv[6] && h[3]) exp_stall++;
    endtask

    // Monitor: one comparison per queued cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_got = {hold_pc, hold_ifid, hold_idex, hold_exmem,
                       flush_ifid, flush_idex, flush_exmem, flush_memwb,
                       pc_exc, div_busy, div_done, state, stall_cnt};
            chk_cnt++;
            if (mon_got === mon_e.v) pass_cnt++;
            else $display("FAIL %s: got %h expected %h", mon_e.nm, mon_got, mon_e.v);
        end
    end

    initial begin
        // Reset and simple hazards
        cyc(7'b0000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "reset");
        cyc(IDLE,       4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "idle");
        cyc(7'b1000010, 4'b1100, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, "load_use");
        cyc(IDLE,       4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "after_load_use");
        cyc(7'b1000001, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, "branch");
        cyc(7'b1000011, 4'b1100, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, "lu_over_branch");

        // Divide with a dependent HI/LO reader
        cyc(DS, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "div_start");
        for (int k = 1; k <= 32; k++)
            cyc(7'b1000100, 4'b1110, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd1, "div_hilo");
        cyc(IDLE, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "div_done");
        cyc(IDLE, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "done_pulse_end");

        // Memory stall in the middle of a divide
        cyc(DS, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "div_start2");
        for (int k = 1; k <= 4; k++)
            cyc(IDLE, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, "div_run");
        cyc(7'b1010100, 4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd1, "mem_over_hilo");
        cyc(7'b1010000, 4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd2, "mem_wait");
        cyc(7'b1010000, 4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd2, "mem_wait");
        cyc(IDLE,       4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, "mem_exit");
        for (int k = 9; k <= 32; k++)
            cyc(IDLE, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, "div_resume");
        cyc(IDLE, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, "div_done2");

        // Exception with memory stall and branch in the same cycle
        cyc(DS, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "div_start3");
        for (int k = 1; k <= 3; k++)
            cyc(IDLE, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, "div_run3");
        cyc(7'b1110001, 4'b0000, 4'b1110, 1'b1, 1'b1, 1'b0, 2'd1, "exc_mem_branch");
        cyc(IDLE,       4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "exc_cleared");
        cyc(IDLE,       4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "exc_no_done");

        // Reset while the countdown holds 10
        cyc(DS, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "div_start4");
        for (int k = 1; k <= 22; k++)
            cyc(IDLE, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, "div_run4");
        cyc(7'b0000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "rst_mid_div");
        cyc(7'b0000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "rst_hold");
        cyc(IDLE,       4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "rst_release");
        cyc(IDLE,       4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "rst_no_done");
        cyc(7'b1000010, 4'b1100, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, "load_use_post_rst");
        cyc(IDLE,       4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, "final_idle");

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk_cnt++;
        if (q.size() == 0) pass_cnt++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
